// File: rtl/class_argmax_if.sv
// class_argmax_if: start/done handshake plus score-bank read port of the argmax stage.
`default_nettype none

interface class_argmax_if #(
    parameter int IDX_W = 4
);
    logic             start;
    logic [31:0]      score_in;
    logic [IDX_W-1:0] score_idx;
    logic             done;
    logic [IDX_W-1:0] class_out;
    logic [31:0]      max_score;

    // master: the controller / score bank side
    modport master (
        output start,
        output score_in,
        input  score_idx,
        input  done,
        input  class_out,
        input  max_score
    );

    // slave: the argmax block
    modport slave (
        input  start,
        input  score_in,
        output score_idx,
        output done,
        output class_out,
        output max_score
    );
endinterface

`default_nettype wire

// File: rtl/class_argmax.sv
// +------------------------------------------------------------------------+
// | class_argmax: sequential argmax over IEEE-754 scores in the score bank  |
// | rev 1.0 - initial release                                               |
// +------------------------------------------------------------------------+
`default_nettype none

module class_argmax #(
    parameter int NUM_CLASSES = 10,
    parameter int IDX_W       = 4
) (
    input  wire logic     clk,
    input  wire logic     reset,
    class_argmax_if.slave bus
);

    localparam logic [IDX_W-1:0] C_LAST    = IDX_W'(NUM_CLASSES - 1);
    localparam logic [31:0]      C_NEG_INF = 32'hFF80_0000;

    typedef enum logic [2:0] {
        S_WAIT  = 3'd0,
        S_CLEAR = 3'd1,
        S_READ  = 3'd2,
        S_CMP   = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [IDX_W-1:0] r_idx;
    logic             r_best_valid;
    logic [IDX_W-1:0] r_class;
    logic [31:0]      r_max;
    logic             r_done;
    logic             w_nan;
    logic             w_replace;

    // Bit-level a > b; signed zeros compare equal, non-NaN operands only.
    function automatic logic f_gt(input logic [31:0] a, input logic [31:0] b);
        logic a_zero;
        logic b_zero;
        a_zero = (a[30:0] == 31'd0);
        b_zero = (b[30:0] == 31'd0);
        if (a_zero && b_zero)
            f_gt = 1'b0;
        else if (a[31] != b[31])
            f_gt = ~a[31];
        else if (!a[31])
            f_gt = (a[30:0] > b[30:0]);
        else
            f_gt = (a[30:0] < b[30:0]);
    endfunction

    assign w_nan     = (bus.score_in[30:23] == 8'hFF) && (bus.score_in[22:0] != 23'd0);
    assign w_replace = !w_nan && (!r_best_valid || f_gt(bus.score_in, r_max));

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_state <= S_WAIT;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_WAIT:  if (bus.start) w_next = S_CLEAR;
            S_CLEAR: w_next = S_READ;
            S_READ:  w_next = S_CMP;
            S_CMP:   w_next = (r_idx == C_LAST) ? S_DONE : S_READ;
            S_DONE:  if (!bus.start) w_next = S_WAIT;
            default: w_next = S_WAIT;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_idx        <= '0;
            r_best_valid <= 1'b0;
            r_class      <= '0;
            r_max        <= 32'h0000_0000;
            r_done       <= 1'b0;
        end else begin
            // done lags the state by one cycle to line up with the bank pipeline
            r_done <= (r_state == S_DONE);
            case (r_state)
                S_CLEAR: begin
                    r_idx        <= '0;
                    r_best_valid <= 1'b0;
                    r_class      <= '0;
                    r_max        <= C_NEG_INF;
                end
                S_CMP: begin
                    if (w_replace) begin
                        r_class      <= r_idx;
                        r_max        <= bus.score_in;
                        r_best_valid <= 1'b1;
                    end
                    if (r_idx != C_LAST)
                        r_idx <= r_idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.score_idx = r_idx;
    assign bus.done      = r_done;
    assign bus.class_out = r_class;
    assign bus.max_score = r_max;

endmodule

`default_nettype wire

// File: tb/tb_class_argmax.sv
// tb_class_argmax: directed scans of class_argmax behind a registered score bank.
`default_nettype none

module tb_class_argmax;

    logic clk;
    logic reset;
    logic [31:0] mem [0:9];
    logic [31:0] bank_q;
    int   idx_log [0:127];
    int   n_cmp;
    int   n_bad;

    class_argmax_if #(.IDX_W(4)) dut_if ();

    class_argmax #(.NUM_CLASSES(10), .IDX_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (dut_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) bank_q <= mem[dut_if.score_idx];
    assign dut_if.score_in = bank_q;

    task automatic fill(input logic [31:0] v);
        for (int i = 0; i < 10; i++) mem[i] = v;
    endtask

    // Raise start, optionally drop it after the first edge, and wait for done.
    task automatic run_scan(input bit hold, output int lat, output bit ok);
        int i;
        @(negedge clk);
        dut_if.start = 1'b1;
        lat = 0;
        ok  = 1'b0;
        i   = 1;
        while (!ok && i <= 100) begin
            @(posedge clk);
            #1;
            if (!hold) dut_if.start = 1'b0;
            idx_log[i] = int'(dut_if.score_idx);
            if (dut_if.done) begin
                ok  = 1'b1;
                lat = i;
            end
            i++;
        end
    endtask

    task automatic release_start();
        @(negedge clk);
        dut_if.start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        dut_if.start = 1'b0;
        fill(32'h0);
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (dut_if.done !== 1'b0) begin n_bad++; $display("FAIL reset_done got %0b want 0", dut_if.done); end
        n_cmp++; if (dut_if.class_out !== 4'd0) begin n_bad++; $display("FAIL reset_class got %0d want 0", dut_if.class_out); end
        n_cmp++; if (dut_if.max_score !== 32'h0) begin n_bad++; $display("FAIL reset_max got %h want 00000000", dut_if.max_score); end
        n_cmp++; if (dut_if.score_idx !== 4'd0) begin n_bad++; $display("FAIL reset_idx got %0d want 0", dut_if.score_idx); end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_basic();
        int lat; bit ok; int bad_idx;
        mem[0] = 32'h3F800000; mem[1] = 32'h40200000; mem[2] = 32'hC0400000; mem[3] = 32'h3F000000;
        for (int i = 4; i < 10; i++) mem[i] = 32'h0;
        run_scan(1'b1, lat, ok);
        n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL basic_timeout got %0b want 1", ok); end
        n_cmp++; if (lat !== 23) begin n_bad++; $display("FAIL basic_latency got %0d want 23 edges", lat); end
        n_cmp++; if (dut_if.class_out !== 4'd1) begin n_bad++; $display("FAIL basic_class got %0d want 1", dut_if.class_out); end
        n_cmp++; if (dut_if.max_score !== 32'h40200000) begin n_bad++; $display("FAIL basic_max got %h want 40200000", dut_if.max_score); end
        n_cmp++; if (dut_if.score_idx !== 4'd9) begin n_bad++; $display("FAIL basic_idx_hold got %0d want 9", dut_if.score_idx); end
        bad_idx = -1;
        for (int k = 0; k < 10; k++)
            if (idx_log[2+2*k] != k || idx_log[3+2*k] != k) bad_idx = k;
        n_cmp++; if (bad_idx !== -1) begin n_bad++; $display("FAIL basic_idx_step got bad index %0d want none", bad_idx); end
        release_start();
    endtask

    task automatic test_reset_mid_scan();
        int lat; bit ok;
        fill(32'h0);
        mem[2] = 32'h3F800000;
        @(negedge clk);
        dut_if.start = 1'b1;
        repeat (11) @(posedge clk);
        #1;
        n_cmp++; if (dut_if.class_out !== 4'd2) begin n_bad++; $display("FAIL mid_class_before got %0d want 2", dut_if.class_out); end
        #1;
        reset = 1'b1;
        dut_if.start = 1'b0;
        #1;
        n_cmp++; if (dut_if.done !== 1'b0) begin n_bad++; $display("FAIL mid_done got %0b want 0", dut_if.done); end
        n_cmp++; if (dut_if.class_out !== 4'd0) begin n_bad++; $display("FAIL mid_class got %0d want 0", dut_if.class_out); end
        n_cmp++; if (dut_if.max_score !== 32'h0) begin n_bad++; $display("FAIL mid_max got %h want 00000000", dut_if.max_score); end
        n_cmp++; if (dut_if.score_idx !== 4'd0) begin n_bad++; $display("FAIL mid_idx got %0d want 0", dut_if.score_idx); end
        @(negedge clk);
        reset = 1'b0;
        run_scan(1'b1, lat, ok);
        n_cmp++; if (lat !== 23) begin n_bad++; $display("FAIL mid_rescan_latency got %0d want 23", lat); end
        n_cmp++; if (dut_if.class_out !== 4'd2) begin n_bad++; $display("FAIL mid_rescan_class got %0d want 2", dut_if.class_out); end
        n_cmp++; if (dut_if.max_score !== 32'h3F800000) begin n_bad++; $display("FAIL mid_rescan_max got %h want 3F800000", dut_if.max_score); end
        release_start();
    endtask

    task automatic test_negative();
        int lat; bit ok;
        fill(32'hC0400000);
        mem[7] = 32'hBF800000;
        run_scan(1'b1, lat, ok);
        n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL neg_timeout got %0b want 1", ok); end
        n_cmp++; if (dut_if.class_out !== 4'd7) begin n_bad++; $display("FAIL neg_class got %0d want 7", dut_if.class_out); end
        n_cmp++; if (dut_if.max_score !== 32'hBF800000) begin n_bad++; $display("FAIL neg_max got %h want BF800000", dut_if.max_score); end
        release_start();
    endtask

    task automatic test_ties();
        int lat; bit ok;
        fill(32'h3F800000);
        mem[3] = 32'h40A00000; mem[8] = 32'h40A00000;
        run_scan(1'b1, lat, ok);
        n_cmp++; if (dut_if.class_out !== 4'd3) begin n_bad++; $display("FAIL tie_class got %0d want 3", dut_if.class_out); end
        n_cmp++; if (dut_if.max_score !== 32'h40A00000) begin n_bad++; $display("FAIL tie_max got %h want 40A00000", dut_if.max_score); end
        release_start();
        fill(32'h80000000);
        mem[5] = 32'h00000000;
        run_scan(1'b1, lat, ok);
        n_cmp++; if (dut_if.class_out !== 4'd0) begin n_bad++; $display("FAIL zero_class got %0d want 0", dut_if.class_out); end
        n_cmp++; if (dut_if.max_score !== 32'h80000000) begin n_bad++; $display("FAIL zero_max got %h want 80000000", dut_if.max_score); end
        release_start();
    endtask

    task automatic test_nan();
        int lat; bit ok;
        fill(32'h3F800000);
        mem[0] = 32'h7FC00000; mem[6] = 32'h7F800000;
        run_scan(1'b1, lat, ok);
        n_cmp++; if (dut_if.class_out !== 4'd6) begin n_bad++; $display("FAIL inf_class got %0d want 6", dut_if.class_out); end
        n_cmp++; if (dut_if.max_score !== 32'h7F800000) begin n_bad++; $display("FAIL inf_max got %h want 7F800000", dut_if.max_score); end
        release_start();
        fill(32'h7FC00000);
        run_scan(1'b1, lat, ok);
        n_cmp++; if (dut_if.class_out !== 4'd0) begin n_bad++; $display("FAIL allnan_class got %0d want 0", dut_if.class_out); end
        n_cmp++; if (dut_if.max_score !== 32'hFF800000) begin n_bad++; $display("FAIL allnan_max got %h want FF800000", dut_if.max_score); end
        release_start();
    endtask

    task automatic test_handshake();
        int lat; bit ok; int high; bit rescan;
        fill(32'h0);
        mem[4] = 32'h3F800000;
        run_scan(1'b0, lat, ok);
        n_cmp++; if (lat !== 23) begin n_bad++; $display("FAIL pulse_latency got %0d want 23", lat); end
        high = 1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (dut_if.done) high++;
        end
        n_cmp++; if (high !== 1) begin n_bad++; $display("FAIL pulse_done_width got %0d want 1", high); end
        n_cmp++; if (dut_if.class_out !== 4'd4) begin n_bad++; $display("FAIL pulse_class_hold got %0d want 4", dut_if.class_out); end
        run_scan(1'b1, lat, ok);
        rescan = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (!dut_if.done || dut_if.score_idx != 4'd9) rescan = 1'b1;
        end
        n_cmp++; if (rescan !== 1'b0) begin n_bad++; $display("FAIL held_done_dropped got %0b want 0", rescan); end
        release_start();
        n_cmp++; if (dut_if.done !== 1'b0) begin n_bad++; $display("FAIL held_release_done got %0b want 0", dut_if.done); end
        mem[4] = 32'h0; mem[9] = 32'h40000000;
        run_scan(1'b1, lat, ok);
        n_cmp++; if (lat !== 23) begin n_bad++; $display("FAIL restart_latency got %0d want 23", lat); end
        n_cmp++; if (dut_if.class_out !== 4'd9) begin n_bad++; $display("FAIL restart_class got %0d want 9", dut_if.class_out); end
        release_start();
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        dut_if.start = 1'b0;
        test_reset();
        test_basic();
        test_reset_mid_scan();
        test_negative();
        test_ties();
        test_nan();
        test_handshake();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
